io_write_buffer: RTL and testbench

IO_WRITE_BUFFER -- requirements
Module: io_write_buffer

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/io_write_buffer.sv | 143 ++++++++++++++
 tb/tb_io_write_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the small CPU core and its I/O write buffer.
//   WORD_W          : machine word width (address and data)
//   REG_AX..REG_DX  : general register indices
//   OP_*            : instruction opcode constants
//   iobuf_state_t   : output FSM state of io_write_buffer
//   iobuf_lvl_w()   : width needed to count 0..depth entries
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int WORD_W = 16;

    localparam logic [1:0] REG_AX = 2'd0;
    localparam logic [1:0] REG_BX = 2'd1;
    localparam logic [1:0] REG_CX = 2'd2;
    localparam logic [1:0] REG_DX = 2'd3;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_RDI = 4'h7;
    localparam logic [3:0] OP_WRO = 4'h8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } iobuf_state_t;

    // A counter holding 0..depth inclusive needs one bit more than the pointer.
    function automatic int iobuf_lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational view of the head entry, so the
// owner can copy the head into its own register at the same edge it pops.
// Pointers wrap modulo DEPTH (DEPTH must be a power of two, >= 2).
// The owner must never push when full or pop when level is zero.
//   clk, rst (async, active-high)
//   push, wr_data : store wr_data at the write pointer
//   pop           : advance the read pointer
//   rd_data       : entry at the read pointer
//   level         : number of stored entries
//   full          : level == DEPTH
// ---------------------------------------------------------------------------
module sync_fifo
    import cpu_pkg::*;
#(
    parameter int WIDTH = 2 * WORD_W,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = iobuf_lvl_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0] level_reg, level_next;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        // Power-of-two depth: natural overflow of the pointer is the wrap.
        if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

    // Storage is deliberately left out of reset; stale entries are never
    // visible because level gates every pop.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_reg];
    assign level   = level_reg;
    assign full    = (level_reg == LVL_W'(DEPTH));

endmodule

// File: rtl/io_write_buffer.sv
// ---------------------------------------------------------------------------
// io_write_buffer
// Decouples CPU port writes (WRO) from a slow consumer. Writes go into a
// sync_fifo; a two-state FSM moves the head into a registered output slot
// and presents it with a valid/ready handshake, one transaction per cycle
// when the consumer keeps up.
//   clk, rst (async, active-high)
//   wr_valid, wr_addr, wr_data : CPU write strobe and payload
//   full                       : FIFO holds DEPTH entries (CPU stalls on it)
//   out_valid, out_ready       : output handshake
//   out_addr, out_data         : presented transaction (held while stalled)
//   level                      : FIFO occupancy, output slot not counted
//   overflow, ovf_clr          : sticky dropped-write flag and its clear
//   drop_cnt                   : saturating dropped-write counter, present
//                                only when IOBUF_DROP_CNT_EN is defined
// ---------------------------------------------------------------------------
module io_write_buffer
    import cpu_pkg::*;
#(
    parameter int N     = WORD_W,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    input  logic [N-1:0]           wr_addr,
    input  logic [N-1:0]           wr_data,
    output logic                   full,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_addr,
    output logic [N-1:0]           out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
`ifdef IOBUF_DROP_CNT_EN
    input  logic                   ovf_clr,
    output logic [N-1:0]           drop_cnt
`else
    input  logic                   ovf_clr
`endif
);

    iobuf_state_t     state_reg;
    logic [N-1:0]     out_addr_reg;
    logic [N-1:0]     out_data_reg;
    logic             overflow_reg;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             has_data;
    logic             drop;
    logic [2*N-1:0]   fifo_head;
    logic [$clog2(DEPTH):0] fifo_level;

    // full is sampled before the edge, so a pop at the same edge cannot
    // make room for the write that is arriving now.
    assign fifo_push = wr_valid & ~fifo_full;
    assign drop      = wr_valid &  fifo_full;
    assign has_data  = (fifo_level != '0);
    assign fifo_pop  = has_data & ((state_reg == IDLE) | out_ready);

    sync_fifo #(
        .WIDTH (2 * N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({wr_addr, wr_data}),
        .rd_data (fifo_head),
        .level   (fifo_level),
        .full    (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            out_addr_reg <= '0;
            out_data_reg <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (has_data) begin
                        {out_addr_reg, out_data_reg} <= fifo_head;
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    // Without out_ready the slot is held untouched.
                    if (out_ready) begin
                        if (has_data) begin
                            {out_addr_reg, out_data_reg} <= fifo_head;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // A drop at the same edge as a clear wins: the event is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (ovf_clr) begin
            overflow_reg <= 1'b0;
        end
    end

`ifdef IOBUF_DROP_CNT_EN
    logic [N-1:0] drop_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else if (drop) begin
            if (ovf_clr) begin
                drop_cnt_reg <= N'(1);
            end else if (drop_cnt_reg != '1) begin
                drop_cnt_reg <= drop_cnt_reg + N'(1);
            end
        end else if (ovf_clr) begin
            drop_cnt_reg <= '0;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

    assign full      = fifo_full;
    assign level     = fifo_level;
    assign out_valid = (state_reg == SEND);
    assign out_addr  = out_addr_reg;
    assign out_data  = out_data_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_io_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_io_write_buffer
// Scoreboard bench: every write the bench expects to be accepted is pushed
// to sb_q; a monitor pops and compares on each output handshake.
// Inputs change 1 time unit after the rising edge, outputs are sampled on
// the falling edge. Build with +define+IOBUF_DROP_CNT_EN to cover drop_cnt.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_io_write_buffer;

    localparam int N     = 16;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   wr_valid = 1'b0;
    logic [N-1:0]           wr_addr = '0;
    logic [N-1:0]           wr_data = '0;
    logic                   full;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [N-1:0]           out_addr;
    logic [N-1:0]           out_data;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic                   ovf_clr = 1'b0;
`ifdef IOBUF_DROP_CNT_EN
    logic [N-1:0]           drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_q[$];
    logic        stalled = 1'b0;
    logic [31:0] held = '0;
    logic        bp_mode = 1'b0;

    always #5 clk = ~clk;

    io_write_buffer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .full      (full),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow),
`ifdef IOBUF_DROP_CNT_EN
        .ovf_clr   (ovf_clr),
        .drop_cnt  (drop_cnt)
`else
        .ovf_clr   (ovf_clr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_drop_cnt(input string tag, input logic [31:0] exp);
`ifdef IOBUF_DROP_CNT_EN
        check(tag, 32'(drop_cnt), exp);
`else
        if (exp == 32'hFFFF_FFFF) check(tag, 32'(overflow), 32'd0);
`endif
    endtask

    // CPU-style write: stall while full, then one strobe cycle.
    task automatic do_write(input logic [N-1:0] a, input logic [N-1:0] d);
        int n = 0;
        while (full && n < 200) begin
            tick();
            n++;
        end
        if (full) check("write_stall_timeout", 32'(full), 32'd0);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        sb_q.push_back({a, d});
        tick();
        wr_valid = 1'b0;
    endtask

    // Write issued regardless of full; the bench expects it to be dropped.
    task automatic forced_drop(input logic [N-1:0] a, input logic [N-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        check("drain_left", 32'(sb_q.size()), 32'd0);
        tick();
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_level", 32'(level), 32'd0);
    endtask

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (out_valid && stalled) check("stall_hold", {out_addr, out_data}, held);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", {out_addr, out_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] exp;
                    exp = sb_q.pop_front();
                    $display("txn addr=0x%04h data=0x%04h expect=0x%08h", out_addr, out_data, exp);
                    check("out_txn", {out_addr, out_data}, exp);
                end
            end
            stalled = out_valid && !out_ready;
            held    = {out_addr, out_data};
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_mode) out_ready = ~out_ready;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check_drop_cnt("rst_drop_cnt", 32'd0);
        rst = 1'b0;
        tick();

        // Single write: visible after edge t+1, for exactly one cycle
        out_ready = 1'b1;
        wr_valid  = 1'b1;
        wr_addr   = 16'h0003;
        wr_data   = 16'h00AB;
        sb_q.push_back({16'h0003, 16'h00AB});
        tick();                         // edge t
        wr_valid = 1'b0;
        @(negedge clk);
        check("single_no_bypass", 32'(out_valid), 32'd0);
        check("single_level_t", 32'(level), 32'd1);
        tick();                         // edge t+1
        @(negedge clk);
        check("single_valid_t1", 32'(out_valid), 32'd1);
        check("single_data", {out_addr, out_data}, 32'h0003_00AB);
        tick();                         // edge t+2
        @(negedge clk);
        check("single_valid_t2", 32'(out_valid), 32'd0);
        check("single_level_end", 32'(level), 32'd0);
        check("single_sb_empty", 32'(sb_q.size()), 32'd0);
        tick();

        // Fill: one entry in the output slot, four in the FIFO
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) do_write(16'h0100 + 16'(i), 16'(i));
        check("fill_full", 32'(full), 32'd1);
        check("fill_level", 32'(level), 32'd4);
        check("fill_overflow", 32'(overflow), 32'd0);
        check("fill_out_valid", 32'(out_valid), 32'd1);
        check("fill_out_data", 32'(out_data), 32'd1);

        // Overflow: sixth write dropped
        forced_drop(16'h0106, 16'd6);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'd4);
        check_drop_cnt("ovf_drop_cnt", 32'd1);

        // Pop while full does not admit a write; drop beats clear
        out_ready = 1'b1;
        ovf_clr   = 1'b1;
        forced_drop(16'h0107, 16'd7);
        check("pop_full_level", 32'(level), 32'd3);
        check("clr_vs_drop_overflow", 32'(overflow), 32'd1);
        check_drop_cnt("clr_vs_drop_cnt", 32'd1);
        tick();                         // clear alone
        ovf_clr = 1'b0;
        check("clr_overflow", 32'(overflow), 32'd0);
        check_drop_cnt("clr_drop_cnt", 32'd0);
        wait_drain();

        // Streaming: one per cycle, level stays at most 1
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            do_write(16'h0200 + 16'(i), 16'h1000 + 16'(i));
            check("stream_level_le1", 32'(level <= 1), 32'd1);
        end
        check("stream_overflow", 32'(overflow), 32'd0);
        wait_drain();

        // Backpressure: out_ready toggles every cycle
        out_ready = 1'b0;
        bp_mode   = 1'b1;
        for (int i = 0; i < 8; i++) do_write(16'h0300 + 16'(i), 16'h0010 + 16'(i));
        wait_drain();
        bp_mode = 1'b0;
        tick();
        check("bp_overflow", 32'(overflow), 32'd0);

        // Reset in SEND with three entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_write(16'h0400 + 16'(i), 16'h0040 + 16'(i));
        check("pre_rst_level", 32'(level), 32'd3);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_data", 32'(out_data), 32'd0);
        sb_q.delete();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        check("post_rst_idle", 32'(out_valid), 32'd0);
        check("post_rst_level", 32'(level), 32'd0);

        // Still functional after reset
        do_write(16'h0500, 16'h0055);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
